uio_bus_arbiter: RTL and testbench

- Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the tt_um top among N_REQ internal requesters.
- Round-robin grant, per-grant direction (drive or sample), burst hold with forced release, and a pad turnaround gap on direction change.
- Sits directly behind the top-level uio ports; internal engines never touch uio_oe themselves.

---
 rtl/uio_arb_pkg.sv | 25 ++
 rtl/uio_bus_arbiter_rr_picker.sv | 32 +++
 rtl/uio_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter and its helpers.
// Kept separate so future internal arbiters can reuse the pad constants.

package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } arb_state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int UIO_W = 8;

    localparam logic [UIO_W-1:0] OE_ALL  = 8'hFF;
    localparam logic [UIO_W-1:0] OE_NONE = 8'h00;

    // Cyclic increment used to advance round-robin pointers.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
// Returns the winner as both a one-hot vector and an index.

module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                pick[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the bidirectional uio pad bus among N_REQ engines: round-robin grant,
// per-grant direction, burst limit and a pad turnaround gap. Option: UIO_ARB_PRIO0_EN.

module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 15,
    parameter int TURN_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   dir,
    input  logic [N_REQ-1:0]   last,
    input  logic [8*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic               beat,
    output logic [7:0]         rdata,
    output logic               rvalid,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic               busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [1:0] TURN_LAST = 2'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic             own_dir;
    logic             cur_dir;
    logic [7:0]       beat_cnt;
    logic [1:0]       turn_cnt;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic [N_REQ-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_upd_ptr;

    logic [N_REQ-1:0] owner_oh;
    logic [UIO_W-1:0] own_wdata;
    logic             own_req;
    logic             own_last;
    logic             burst_done;
    logic             release_now;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .pick  (pick_oh),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef UIO_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation and leaves the pointer untouched.
    always_comb begin
        sel_oh      = pick_oh;
        sel_idx     = pick_idx;
        sel_upd_ptr = 1'b1;
        if (req[0]) begin
            sel_oh      = N_REQ'(1);
            sel_idx     = '0;
            sel_upd_ptr = 1'b0;
        end
    end
`else
    always_comb begin
        sel_oh      = pick_oh;
        sel_idx     = pick_idx;
        sel_upd_ptr = 1'b1;
    end
`endif

    assign owner_oh  = N_REQ'(1) << owner;
    assign own_wdata = wdata[{owner, 3'b000} +: UIO_W];
    assign own_req   = req[owner];
    assign own_last  = own_req & last[owner];

    // The beat that brings the count to MAX_BURST is still transferred.
    assign burst_done  = own_req && (({1'b0, beat_cnt} + 9'd1) >= 9'(MAX_BURST));
    assign release_now = !own_req || own_last || burst_done || !ena;

    assign beat = |(req & gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            own_dir  <= DIR_READ;
            cur_dir  <= DIR_READ;
            beat_cnt <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            uio_out  <= '0;
            uio_oe   <= OE_NONE;
            rdata    <= '0;
            rvalid   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ena && pick_valid) begin
                        owner   <= sel_idx;
                        own_dir <= dir[sel_idx];
                        busy    <= 1'b1;
                        if (sel_upd_ptr) begin
                            rr_ptr <= IDX_W'(wrap_inc(int'(sel_idx), N_REQ));
                        end
                        if ((dir[sel_idx] != cur_dir) && (TURN_CYC > 0)) begin
                            state    <= TURN;
                            turn_cnt <= '0;
                            gnt      <= '0;
                            uio_oe   <= OE_NONE;
                        end else begin
                            state    <= OWN;
                            cur_dir  <= dir[sel_idx];
                            beat_cnt <= '0;
                            gnt      <= sel_oh;
                            uio_oe   <= (dir[sel_idx] == DIR_WRITE) ? OE_ALL : OE_NONE;
                        end
                    end
                end

                // Pads stay released while the external side changes direction.
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state    <= OWN;
                        cur_dir  <= own_dir;
                        beat_cnt <= '0;
                        gnt      <= owner_oh;
                        uio_oe   <= (own_dir == DIR_WRITE) ? OE_ALL : OE_NONE;
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end

                OWN: begin
                    if (own_req) begin
                        if (own_dir == DIR_WRITE) begin
                            uio_out <= own_wdata;
                        end else begin
                            rdata  <= uio_in;
                            rvalid <= 1'b1;
                        end
                        if (beat_cnt != 8'hFF) begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                    if (release_now) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        uio_oe <= OE_NONE;
                        busy   <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    uio_oe <= OE_NONE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios plus random traffic
// compared cycle by cycle with a transaction-level reference model.

module tb_uio_bus_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 15;
    localparam int TURN = 1;
    localparam logic [31:0] WD = 32'hD3C2_A5B0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req, dir, last;
    logic [31:0] wdata;
    logic [7:0]  uio_in;
    logic [3:0]  gnt;
    logic        beat;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model: who holds the bus, who waits out a turnaround, and the
    // values the pads and grant lines must show after the next edge.
    int          m_owner, m_pend, m_turn_left, m_beats, m_ptr;
    bit          m_bus_dir, m_own_dir;
    logic [3:0]  e_gnt;
    logic [7:0]  e_oe, e_out, e_rdata;
    logic        e_rvalid, e_busy;

    uio_bus_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (MAXB),
        .TURN_CYC  (TURN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .dir     (dir),
        .last    (last),
        .wdata   (wdata),
        .gnt     (gnt),
        .beat    (beat),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_owner = -1; m_pend = -1; m_turn_left = 0; m_beats = 0; m_ptr = 0;
        m_bus_dir = 1'b0; m_own_dir = 1'b0;
        e_gnt = '0; e_oe = '0; e_out = '0; e_rdata = '0; e_rvalid = 1'b0; e_busy = 1'b0;
    endtask

    task automatic pickWinner(output int w);
        w = -1;
`ifdef UIO_ARB_PRIO0_EN
        if (req[0]) begin
            w = 0;
            return;
        end
`endif
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (w < 0 && req[c]) begin
                w = c;
                m_ptr = (c + 1) % N;
            end
        end
    endtask

    task automatic startGrant(input int o);
        m_owner   = o;
        m_beats   = 0;
        m_bus_dir = m_own_dir;
        e_gnt     = 4'b0001 << o;
        e_oe      = m_own_dir ? 8'hFF : 8'h00;
        e_busy    = 1'b1;
    endtask

    task automatic modelStep();
        int w;
        bit b;
        e_rvalid = 1'b0;
        if (m_owner >= 0) begin
            b = req[m_owner];
            if (b) begin
                m_beats++;
                if (m_own_dir) e_out = wdata[m_owner*8 +: 8];
                else begin
                    e_rdata  = uio_in;
                    e_rvalid = 1'b1;
                end
            end
            if (!b || last[m_owner] || m_beats >= MAXB || !ena) begin
                m_owner = -1; e_gnt = '0; e_oe = '0; e_busy = 1'b0;
            end
        end else if (m_pend >= 0) begin
            m_turn_left--;
            if (m_turn_left == 0) begin
                startGrant(m_pend);
                m_pend = -1;
            end
        end else if (ena && req != 0) begin
            pickWinner(w);
            m_own_dir = dir[w];
            if (m_own_dir != m_bus_dir && TURN > 0) begin
                m_pend = w; m_turn_left = TURN; e_busy = 1'b1;
            end else begin
                startGrant(w);
            end
        end
    endtask

    // One clock: check registered outputs, drive the next inputs, check beat, advance model.
    task automatic applyStimulus(input logic [3:0] rq, input logic [3:0] dr, input logic [3:0] ls,
                                 input logic en, input logic [31:0] wd, input logic [7:0] ui);
        @(negedge clk);
        checkOutput("gnt", gnt, e_gnt);
        checkOutput("uio_oe", uio_oe, e_oe);
        if (e_oe == 8'hFF) checkOutput("uio_out", uio_out, e_out);
        checkOutput("rvalid", rvalid, e_rvalid);
        checkOutput("rdata", rdata, e_rdata);
        checkOutput("busy", busy, e_busy);
        req = rq; dir = dr; last = ls; ena = en; wdata = wd; uio_in = ui;
        #1;
        checkOutput("beat", beat, (m_owner >= 0) ? rq[m_owner] : 1'b0);
        modelStep();
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        req = '0; dir = '0; last = '0; ena = 1'b1; wdata = WD; uio_in = '0;
        @(negedge clk);
        modelReset();
        rst = 1'b0;
    endtask

    initial begin
        int nb;
        bit seen;
        logic [3:0] order[$];
        logic [3:0] t3_exp[10];
        t3_exp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

        rst = 1'b1; ena = 1'b0; req = '0; dir = '0; last = '0; wdata = '0; uio_in = '0;
        modelReset();
        #1;
        checkOutput("reset_gnt", gnt, 4'h0);
        checkOutput("reset_oe", uio_oe, 8'h00);
        checkOutput("reset_out", uio_out, 8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        resetDut();

        // Read with no turnaround, stepping uio_in.
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1, WD, 8'h00);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1, WD, 8'h10);
        checkOutput("rd_gnt", gnt, 4'b0100);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1, WD, 8'h11);
        checkOutput("rd_rdata0", rdata, 8'h10);
        checkOutput("rd_rvalid0", rvalid, 1'b1);
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, WD, 8'h12);
        checkOutput("rd_rdata1", rdata, 8'h11);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, WD, 8'h00);
        checkOutput("rd_rdata2", rdata, 8'h12);
        checkOutput("rd_release", gnt, 4'b0000);

        // Write needing a turnaround, three beats of A5.
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, WD, 8'h00);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, WD, 8'h00);
        checkOutput("wr_turn_gnt", gnt, 4'b0000);
        checkOutput("wr_turn_oe", uio_oe, 8'h00);
        checkOutput("wr_turn_busy", busy, 1'b1);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, WD, 8'h00);
        checkOutput("wr_gnt", gnt, 4'b0010);
        checkOutput("wr_oe", uio_oe, 8'hFF);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, WD, 8'h00);
        checkOutput("wr_out", uio_out, 8'hA5);
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b1, WD, 8'h00);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, WD, 8'h00);
        checkOutput("wr_release_gnt", gnt, 4'b0000);
        checkOutput("wr_release_oe", uio_oe, 8'h00);

`ifndef UIO_ARB_PRIO0_EN
        // All four requesting single-beat bursts: rotation with IDLE gaps.
        resetDut();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b1111, 4'b0000, 4'b1111, 1'b1, WD, 8'h00);
            checkOutput($sformatf("rr_seq%0d", i), gnt, t3_exp[i]);
        end

        // Pointer at 2 with req=1011: expect 3, 0, 1.
        resetDut();
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, WD, 8'h00);
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, WD, 8'h00);
        order.delete();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b1011, 4'b0000, 4'b1011, 1'b1, WD, 8'h00);
            if (gnt != 4'b0000) order.push_back(gnt);
        end
        checkOutput("wrap_count", (order.size() >= 3) ? 1 : 0, 1);
        if (order.size() >= 3) begin
            checkOutput("wrap_first", order[0], 4'b1000);
            checkOutput("wrap_second", order[1], 4'b0001);
            checkOutput("wrap_third", order[2], 4'b0010);
        end
`endif

        // Long burst is cut at MAX_BURST beats.
        resetDut();
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus(4'b0011, 4'b0000, 4'b0000, 1'b1, WD, 8'(i));
            if (gnt == 4'b0001 && beat) nb++;
            if (gnt == 4'b0010) seen = 1'b1;
        end
        checkOutput("burst_beats", nb, MAXB);
`ifndef UIO_ARB_PRIO0_EN
        checkOutput("burst_next_owner", seen, 1'b1);
`endif

        // ena dropped mid-write, then asynchronous reset mid-burst.
        resetDut();
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, WD, 8'h00);
            if (gnt == 4'b0010) seen = 1'b1;
        end
        checkOutput("ena_grant_seen", seen, 1'b1);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, WD, 8'h00);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, WD, 8'h00);
        checkOutput("ena_drop_gnt", gnt, 4'b0000);
        checkOutput("ena_drop_oe", uio_oe, 8'h00);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, WD, 8'h00);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, WD, 8'h00);
        checkOutput("regrant_gnt", gnt, 4'b0010);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_gnt", gnt, 4'b0000);
        checkOutput("arst_oe", uio_oe, 8'h00);
        checkOutput("arst_out", uio_out, 8'h00);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_beat", beat, 1'b0);
        checkOutput("arst_rvalid", rvalid, 1'b0);
        req = '0; dir = '0; last = '0;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b1010, 4'b0000, 4'b1010, 1'b1, WD, 8'h00);
        applyStimulus(4'b1010, 4'b0000, 4'b1010, 1'b1, WD, 8'h00);
        checkOutput("post_reset_lowest", gnt, 4'b0010);

`ifdef UIO_ARB_PRIO0_EN
        // Requester 0 keeps winning; requester 2 only after req[0] drops.
        resetDut();
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1, WD, 8'h00);
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1, WD, 8'h00);
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0101, 4'b0000, 4'b0101, 1'b1, WD, 8'h00);
            if (gnt == 4'b0001) nb++;
            if (gnt == 4'b0100) seen = 1'b1;
        end
        checkOutput("prio_wins", nb, 4);
        checkOutput("prio_no_req2", seen, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, WD, 8'h00);
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, WD, 8'h00);
        checkOutput("prio_req2_served", gnt, 4'b0100);
`endif

        // Random traffic against the model.
        resetDut();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom), 4'($urandom), 4'($urandom & $urandom),
                          ($urandom_range(0, 15) != 0), $urandom, 8'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, WD, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
